seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
- Reads a multiplexed, common-cathode 7-segment display bus: active-high segments plus one-hot digit enables.
- Samples each digit's segment pattern once its dwell has settled and encodes it back to BCD, inverting our BCD-to-7-segment decoder table.
- Publishes a multi-digit BCD word only after identical full scans repeat.
- Sits at the front of display-capture/verification designs, reading displays driven by our own decoders or by external instruments.

Parameters:
- DIGITS, 4: number of multiplexed digits.
- SETTLE, 8: consecutive stable cycles required before a digit is sampled (>=1).
- MATCH, 2: consecutive identical legal scans required before publishing (>=1).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  synchronous, active-low reset.
- SEG  input  7  segment lines, bit6=a ... bit0=g, active-high, asynchronous to CLK.
- DIG  input  DIGITS  digit enables, one-hot active-high; DIG[i] selects digit i; asynchronous to CLK.
- BCD_OUT  output  4*DIGITS  published value; digit i at BCD_OUT[4i+3:4i].
- BLANK  output  DIGITS  published blank mask; bit i=1 means digit i was dark.
- VALID  output  1  one-cycle pulse when BCD_OUT/BLANK are (re)published.
- ERR  output  1  one-cycle pulse when a completed scan contains an illegal pattern.
- LOCKED  output  1  high while the match count is >= MATCH.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - BCD_OUT=0, BLANK=0, VALID=0, ERR=0, LOCKED=0.
  - Clears synchronisers, settle counter, scan buffer, captured mask, previous-scan store and match count.
  - Reset mid-scan discards the partial scan.
- Input sync: SEG and DIG each pass a 2-flop synchroniser. All timing below uses the synchronised values (sSEG, sDIG).
- Settle counter:
  - Increments when sDIG is exactly one-hot and {sSEG,sDIG} equals the previous cycle's value.
  - Otherwise clears to 0.
  - Saturates at SETTLE.
  - The sample fires on the single cycle the counter reaches SETTLE, giving exactly one sample per dwell.
  - sDIG all-zero or multi-hot never samples.
- Encoding (sample -> 4-bit code):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - 00 -> code F with blank flag set.
  - Any other pattern -> code E with illegal flag set.
- Sample write: code, blank flag and illegal flag go to scan-buffer slot i, and captured-mask bit i is set. Re-sampling a digit before the scan completes overwrites its slot; the mask is unchanged.
- Scan complete: all mask bits set. It is evaluated on the edge after the last sample write, and on that edge the mask clears.
- On scan complete:
  - Any illegal slot: ERR pulses, match count=0, LOCKED=0, previous-scan store cleared.
  - Otherwise, scan equals previous store (codes and blank flags): match count increments, saturating at MATCH.
  - Otherwise: match count=1.
  - Previous store is then updated with the scan.
- Publish: if the post-update match count is >= MATCH, on the same edge:
  - BCD_OUT and BLANK load the scan.
  - VALID pulses for one cycle.
  - LOCKED=1.
- Republishing: every further matching scan republishes and pulses VALID.
- Mismatching legal scan: LOCKED drops to 0 and BCD_OUT/BLANK hold their last published value.
- MATCH=1: every legal scan publishes.
- Latency: VALID is high in the 2nd cycle after the cycle in which the last digit's sample fires. Add 2 cycles of synchroniser delay relative to the raw pins.
- Simultaneous events: a sample firing on the same edge as scan-complete evaluation is written into the freshly cleared mask, so it belongs to the next scan.

Test Plan:
1. Scan buffer and publish: SETTLE=8, MATCH=2; drive digits 0..3 with patterns 7B,6D,7E,6D (BCD_OUT[15:0]=16'h2029), 16-cycle dwell each, 3 scans.
   - No VALID after scan 1.
   - VALID after scan 2 with BCD_OUT=16'h2029, BLANK=0, LOCKED=1.
   - VALID again after scan 3.
2. Short dwell: same patterns but dwell = 2+SETTLE-1 cycles. -> No sample, no VALID, LOCKED stays 0.
3. Illegal pattern: locked on 16'h2029, then digit 2 shows 0x01. -> ERR pulse after that scan; LOCKED=0; BCD_OUT still 16'h2029; two clean scans of 16'h1234 relock with VALID.
4. Blank digit: digit 3 shows 00, others 7E. -> Published BLANK=4'b1000 and BCD_OUT[15:12]=F.
5. Bus glitches: DIG=0 gaps between dwells, a multi-hot DIG=4'b0011 for 20 cycles, and a SEG change mid-dwell that restarts settling. -> Only clean dwells sample; the value is still correct.
6. Reset mid-scan: assert RST_N=0 for 1 cycle after 2 digits are sampled. -> All outputs 0; lock needs MATCH full fresh scans.

Source files
------------

// File: rtl/seg7_scan_reader_if.sv
// Display-bus bundle for the 7-segment scan reader: the raw multiplexed pins
// coming in and the published BCD word, blank mask and status pulses going out.
interface seg7_scan_reader_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          SEG;      // bit6=a ... bit0=g, active-high
  logic [DIGITS-1:0]   DIG;      // one-hot digit enables
  logic [4*DIGITS-1:0] BCD_OUT;  // digit i at [4i+3:4i]
  logic [DIGITS-1:0]   BLANK;    // bit i set when digit i was dark
  logic                VALID;
  logic                ERR;
  logic                LOCKED;

  // Display driver / capture environment side
  modport master (
    output SEG, DIG,
    input  BCD_OUT, BLANK, VALID, ERR, LOCKED
  );

  // Scan reader side
  modport slave (
    input  SEG, DIG,
    output BCD_OUT, BLANK, VALID, ERR, LOCKED
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Multiplexed common-cathode 7-segment bus reader. Synchronises the pins,
// samples each digit once per settled dwell, decodes the pattern back to BCD
// and publishes the full word only after MATCH identical legal scans.
module seg7_scan_reader #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 8,
  parameter int MATCH  = 2
) (
  input logic               CLK,
  input logic               RST_N,
  seg7_scan_reader_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int MCH_W = (MATCH > 1) ? $clog2(MATCH + 1) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [MCH_W-1:0] MATCH_C  = MCH_W'(MATCH);

  // Synchronisers and settle tracking
  logic [6:0]          seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [DIGITS-1:0]   dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d;
  logic [6+DIGITS:0]   hist_q, hist_d;       // last cycle's {sSEG,sDIG}
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fired_q, fired_d;     // this dwell already sampled

  // Scan buffer and captured mask
  logic [4*DIGITS-1:0] code_q, code_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   ill_q, ill_d;
  logic [DIGITS-1:0]   mask_q, mask_d;

  // Previous-scan store and match tracking
  logic [4*DIGITS-1:0] prev_code_q, prev_code_d;
  logic [DIGITS-1:0]   prev_blank_q, prev_blank_d;
  logic [MCH_W-1:0]    match_q, match_d;

  // Published outputs
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_out_q, blank_out_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                locked_q, locked_d;

  // Combinational helpers
  logic                onehot;
  logic                stable;
  logic                fire;
  logic                scan_done;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          enc_code;
  logic                enc_blank;
  logic                enc_ill;

  // Next-state logic: settle/sample, scan-buffer write, scan evaluation and publish
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (which would infer a latch).
    seg_s1_d     = bus.SEG;
    seg_s2_d     = seg_s1_q;
    dig_s1_d     = bus.DIG;
    dig_s2_d     = dig_s1_q;
    hist_d       = {seg_s2_q, dig_s2_q};
    cnt_d        = '0;
    fired_d      = 1'b0;
    idx          = '0;
    enc_code     = 4'hE;
    enc_blank    = 1'b0;
    enc_ill      = 1'b0;
    code_d       = code_q;
    blank_d      = blank_q;
    ill_d        = ill_q;
    mask_d       = mask_q;
    prev_code_d  = prev_code_q;
    prev_blank_d = prev_blank_q;
    match_d      = match_q;
    bcd_d        = bcd_q;
    blank_out_d  = blank_out_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    locked_d     = locked_q;

    // Settle: count consecutive cycles of an unchanged, one-hot bus value
    onehot = (dig_s2_q != '0) && ((dig_s2_q & (dig_s2_q - 1'b1)) == '0);
    stable = onehot && ({seg_s2_q, dig_s2_q} == hist_q);
    if (stable) begin
      cnt_d = (cnt_q == SETTLE_C) ? cnt_q : cnt_q + CNT_W'(1);
    end
    // The sample is taken the first cycle the saturated count is seen while
    // the bus is still holding, so the captured pattern is the settled one.
    fire    = stable && (cnt_q == SETTLE_C) && !fired_q;
    fired_d = stable && (fired_q || fire);

    for (int i = 0; i < DIGITS; i++) begin
      if (dig_s2_q[i]) idx = IDX_W'(i);
    end

    // Inverse of the BCD-to-7-segment decoder table
    unique case (seg_s2_q)
      7'h7E:   enc_code = 4'h0;
      7'h30:   enc_code = 4'h1;
      7'h6D:   enc_code = 4'h2;
      7'h79:   enc_code = 4'h3;
      7'h33:   enc_code = 4'h4;
      7'h5B:   enc_code = 4'h5;
      7'h5F:   enc_code = 4'h6;
      7'h70:   enc_code = 4'h7;
      7'h7F:   enc_code = 4'h8;
      7'h7B:   enc_code = 4'h9;
      7'h00: begin
        enc_code  = 4'hF;
        enc_blank = 1'b1;
      end
      default: begin
        enc_code = 4'hE;
        enc_ill  = 1'b1;
      end
    endcase

    // Scan evaluation works on the buffer as it stood before this edge
    scan_done = &mask_q;
    if (scan_done) begin
      mask_d = '0;
      if (|ill_q) begin
        err_d        = 1'b1;
        match_d      = '0;
        locked_d     = 1'b0;
        prev_code_d  = '0;
        prev_blank_d = '0;
      end else begin
        if ((code_q == prev_code_q) && (blank_q == prev_blank_q)) begin
          match_d = (match_q == MATCH_C) ? match_q : match_q + MCH_W'(1);
        end else begin
          match_d = MCH_W'(1);
        end
        prev_code_d  = code_q;
        prev_blank_d = blank_q;
        if (match_d >= MATCH_C) begin
          bcd_d       = code_q;
          blank_out_d = blank_q;
          valid_d     = 1'b1;
          locked_d    = 1'b1;
        end else begin
          locked_d    = 1'b0;
        end
      end
    end

    // A sample on the completion edge lands in the freshly cleared mask
    if (fire) begin
      code_d[4*idx +: 4] = enc_code;
      blank_d[idx]       = enc_blank;
      ill_d[idx]         = enc_ill;
      mask_d[idx]        = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RST_N) begin
      seg_s1_q     <= '0;
      seg_s2_q     <= '0;
      dig_s1_q     <= '0;
      dig_s2_q     <= '0;
      hist_q       <= '0;
      cnt_q        <= '0;
      fired_q      <= 1'b0;
      // NOTE: the scan buffer and previous-scan store are reset because stale contents would otherwise count toward a match.
      code_q       <= '0;
      blank_q      <= '0;
      ill_q        <= '0;
      mask_q       <= '0;
      prev_code_q  <= '0;
      prev_blank_q <= '0;
      match_q      <= '0;
      bcd_q        <= '0;
      blank_out_q  <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      seg_s1_q     <= seg_s1_d;
      seg_s2_q     <= seg_s2_d;
      dig_s1_q     <= dig_s1_d;
      dig_s2_q     <= dig_s2_d;
      hist_q       <= hist_d;
      cnt_q        <= cnt_d;
      fired_q      <= fired_d;
      code_q       <= code_d;
      blank_q      <= blank_d;
      ill_q        <= ill_d;
      mask_q       <= mask_d;
      prev_code_q  <= prev_code_d;
      prev_blank_q <= prev_blank_d;
      match_q      <= match_d;
      bcd_q        <= bcd_d;
      blank_out_q  <= blank_out_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
    end
  end

  assign bus.BCD_OUT = bcd_q;
  assign bus.BLANK   = blank_out_q;
  assign bus.VALID   = valid_q;
  assign bus.ERR     = err_q;
  assign bus.LOCKED  = locked_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed display scenarios plus randomized scans,
// all compared every cycle against a behavioural model of the reader.
module tb_seg7_scan_reader;

  localparam int D      = 4;
  localparam int SETTLE = 8;
  localparam int MATCH  = 2;

  localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                      7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  logic clk;
  logic rst_n;

  seg7_scan_reader_if #(.DIGITS(D)) bus ();

  seg7_scan_reader #(.DIGITS(D), .SETTLE(SETTLE), .MATCH(MATCH)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]   m_s1_seg, m_s2_seg, m_last_seg;
  logic [D-1:0] m_s1_dig, m_s2_dig, m_last_dig;
  int           m_run;
  int           m_code [D];
  bit           m_blk  [D];
  bit           m_ill  [D];
  bit           m_got  [D];
  int           m_prev_code [D];
  bit           m_prev_blk  [D];
  int           m_match;
  logic [15:0]  m_bcd;
  logic [3:0]   m_blank;
  bit           m_valid, m_err, m_locked;
  bit           m_live = 0;
  bit           m_fire, m_all, m_any_ill, m_same;
  int           m_idx;

  function automatic int enc(input logic [6:0] s);
    for (int v = 0; v < 10; v++) if (PAT[v] == s) return v;
    return (s == 7'h00) ? 15 : 14;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1_seg = 0; m_s2_seg = 0; m_last_seg = 0;
      m_s1_dig = 0; m_s2_dig = 0; m_last_dig = 0;
      m_run = 0; m_match = 0;
      for (int i = 0; i < D; i++) begin
        m_code[i] = 0; m_blk[i] = 0; m_ill[i] = 0; m_got[i] = 0;
        m_prev_code[i] = 0; m_prev_blk[i] = 0;
      end
      m_bcd = 0; m_blank = 0; m_valid = 0; m_err = 0; m_locked = 0;
      m_live = 1;
    end else begin
      // Run length of the synchronised bus value; a dwell samples once,
      // after SETTLE stable repeats following the change cycle.
      if ({m_s2_seg, m_s2_dig} == {m_last_seg, m_last_dig}) m_run++;
      else m_run = 1;
      m_fire = $onehot(m_s2_dig) && (m_run == SETTLE + 2);

      m_valid = 0;
      m_err   = 0;
      m_all   = 1;
      for (int i = 0; i < D; i++) m_all &= m_got[i];
      if (m_all) begin
        m_any_ill = 0;
        m_same    = 1;
        for (int i = 0; i < D; i++) begin
          m_got[i] = 0;
          m_any_ill |= m_ill[i];
          if (m_code[i] != m_prev_code[i] || m_blk[i] != m_prev_blk[i]) m_same = 0;
        end
        if (m_any_ill) begin
          m_err = 1; m_match = 0; m_locked = 0;
          for (int i = 0; i < D; i++) begin m_prev_code[i] = 0; m_prev_blk[i] = 0; end
        end else begin
          m_match = m_same ? ((m_match + 1 > MATCH) ? MATCH : m_match + 1) : 1;
          for (int i = 0; i < D; i++) begin m_prev_code[i] = m_code[i]; m_prev_blk[i] = m_blk[i]; end
          if (m_match >= MATCH) begin
            for (int i = 0; i < D; i++) begin
              m_bcd[4*i +: 4] = 4'(m_code[i]);
              m_blank[i]      = m_blk[i];
            end
            m_valid = 1; m_locked = 1;
          end else begin
            m_locked = 0;
          end
        end
      end

      if (m_fire) begin
        for (int i = 0; i < D; i++) if (m_s2_dig[i]) m_idx = i;
        m_code[m_idx] = enc(m_s2_seg);
        m_blk[m_idx]  = (m_code[m_idx] == 15);
        m_ill[m_idx]  = (m_code[m_idx] == 14);
        m_got[m_idx]  = 1;
      end

      m_last_seg = m_s2_seg; m_last_dig = m_s2_dig;
      m_s2_seg = m_s1_seg;   m_s2_dig = m_s1_dig;
      m_s1_seg = bus.SEG;    m_s1_dig = bus.DIG;
    end
  end

  // Every-cycle comparison against the model, plus pulse counters
  always @(negedge clk) begin
    if (m_live) begin
      check("bcd_out", 32'(bus.BCD_OUT), 32'(m_bcd));
      check("blank",   32'(bus.BLANK),   32'(m_blank));
      check("valid",   32'(bus.VALID),   32'(m_valid));
      check("err",     32'(bus.ERR),     32'(m_err));
      check("locked",  32'(bus.LOCKED),  32'(m_locked));
      if (bus.VALID) valid_cnt++;
      if (bus.ERR)   err_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dwell(input int d, input logic [6:0] s, input int n);
    bus.DIG = D'(1 << d);
    bus.SEG = s;
    cycles(n);
  endtask

  task automatic idle(input int n);
    bus.DIG = '0;
    bus.SEG = '0;
    cycles(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  // pats holds digit i's pattern at [7i+:7]
  task automatic scan(input logic [27:0] pats, input int n);
    for (int i = 0; i < D; i++) dwell(i, pats[7*i +: 7], n);
    idle(8);
  endtask

  function automatic logic [27:0] pats_of(input logic [15:0] v);
    logic [27:0] p;
    for (int i = 0; i < D; i++) p[7*i +: 7] = PAT[v[4*i +: 4]];
    return p;
  endfunction

  int v0, e0;
  logic [27:0] p_a, p_b;
  logic [6:0]  rnd [D];
  int          ord [D];

  initial begin
    rst_n   = 1'b0;
    bus.SEG = '0;
    bus.DIG = '0;
    cycles(3);
    rst_n = 1'b1;

    // Reset state
    check("reset_bcd",    32'(bus.BCD_OUT), 32'h0);
    check("reset_locked", 32'(bus.LOCKED),  32'h0);

    // 1. Publish after two identical scans, republish on the third
    p_a = pats_of(16'h2029);
    v0 = valid_cnt;
    scan(p_a, 16);
    check("t1_no_valid_scan1", 32'(valid_cnt - v0), 32'd0);
    scan(p_a, 16);
    check("t1_valid_scan2",  32'(valid_cnt - v0), 32'd1);
    check("t1_bcd",          32'(bus.BCD_OUT),    32'h2029);
    check("t1_blank",        32'(bus.BLANK),      32'h0);
    check("t1_locked",       32'(bus.LOCKED),     32'h1);
    check("t1_model_bcd",    32'(m_bcd),          32'h2029);
    check("t1_model_locked", 32'(m_locked),       32'h1);
    scan(p_a, 16);
    check("t1_valid_scan3",  32'(valid_cnt - v0), 32'd2);

    // 2. Dwell of SETTLE+1 cycles never samples
    do_reset();
    v0 = valid_cnt;
    repeat (3) scan(p_a, SETTLE + 1);
    check("t2_no_valid",   32'(valid_cnt - v0), 32'd0);
    check("t2_locked_low", 32'(bus.LOCKED),     32'h0);
    scan(p_a, 16);
    check("t2_one_clean_scan_no_valid", 32'(valid_cnt - v0), 32'd0);

    // 3. Illegal pattern breaks lock; clean scans relock on a new value
    do_reset();
    scan(p_a, 16);
    scan(p_a, 16);
    e0 = err_cnt;
    v0 = valid_cnt;
    p_b = p_a;
    p_b[14 +: 7] = 7'h01;
    scan(p_b, 16);
    check("t3_err_pulse",  32'(err_cnt - e0), 32'd1);
    check("t3_locked_low", 32'(bus.LOCKED),   32'h0);
    check("t3_bcd_hold",   32'(bus.BCD_OUT),  32'h2029);
    check("t3_model_err_count_match", 32'(m_match), 32'd0);
    scan(pats_of(16'h1234), 16);
    scan(pats_of(16'h1234), 16);
    check("t3_relock_valid", 32'(valid_cnt - v0), 32'd1);
    check("t3_relock_bcd",   32'(bus.BCD_OUT),    32'h1234);
    check("t3_relock",       32'(bus.LOCKED),     32'h1);

    // 4. Dark digit 3
    do_reset();
    p_b = {7'h00, 7'h7E, 7'h7E, 7'h7E};
    scan(p_b, 16);
    scan(p_b, 16);
    check("t4_blank", 32'(bus.BLANK),   32'h8);
    check("t4_bcd",   32'(bus.BCD_OUT), 32'hF000);

    // 5. Gaps, multi-hot enables and a mid-dwell segment change
    do_reset();
    v0 = valid_cnt;
    repeat (2) begin
      dwell(0, 7'h7F, 16);
      idle(3);
      bus.DIG = 4'b0011;
      bus.SEG = 7'h30;
      cycles(20);
      idle(2);
      dwell(1, 7'h30, 5);
      dwell(1, 7'h70, 16);
      idle(3);
      dwell(2, 7'h5F, 16);
      idle(3);
      dwell(3, 7'h5B, 16);
      idle(8);
    end
    check("t5_valid",  32'(valid_cnt - v0), 32'd1);
    check("t5_bcd",    32'(bus.BCD_OUT),    32'h5678);
    check("t5_locked", 32'(bus.LOCKED),     32'h1);

    // 6. Reset after two digits of a scan
    do_reset();
    scan(p_a, 16);
    scan(p_a, 16);
    dwell(0, p_a[0 +: 7], 16);
    dwell(1, p_a[7 +: 7], 16);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("t6_bcd_zero",    32'(bus.BCD_OUT), 32'h0);
    check("t6_blank_zero",  32'(bus.BLANK),   32'h0);
    check("t6_locked_zero", 32'(bus.LOCKED),  32'h0);
    check("t6_valid_zero",  32'(bus.VALID),   32'h0);
    v0 = valid_cnt;
    dwell(2, p_a[14 +: 7], 16);
    dwell(3, p_a[21 +: 7], 16);
    idle(8);
    scan(p_a, 16);
    check("t6_no_valid_first_fresh", 32'(valid_cnt - v0), 32'd0);
    scan(p_a, 16);
    check("t6_valid_second_fresh",   32'(valid_cnt - v0), 32'd1);
    check("t6_relocked",             32'(bus.LOCKED),     32'h1);

    // Randomized scans: random values, order, dwell, gaps and short glitches
    do_reset();
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < D; i++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 18)       rnd[i] = PAT[r % 10];
        else if (r == 18) rnd[i] = 7'h00;
        else              rnd[i] = 7'($urandom);
      end
      repeat ($urandom_range(1, 3)) begin
        for (int i = 0; i < D; i++) ord[i] = i;
        for (int i = D - 1; i > 0; i--) begin
          int j, t;
          j = $urandom_range(0, i);
          t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < D; i++) begin
          if ($urandom_range(0, 7) == 0)
            dwell($urandom_range(0, D - 1), 7'($urandom), $urandom_range(1, SETTLE + 1));
          dwell(ord[i], rnd[ord[i]], $urandom_range(SETTLE + 2, SETTLE + 10));
          idle($urandom_range(0, 3));
        end
      end
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
